// File: rtl/combo_lock_gen.sv
// combo_lock_gen: parametrised alternating-direction combination lock.
// Define COMBO_LOCK_LOCKOUT_EN to build in the brute-force lockout.
module combo_lock_gen #(
    parameter int unsigned POS_W = 5,
    parameter int unsigned STEPS = 3,
    parameter int unsigned IDX_W = 2,
    parameter logic [POS_W*STEPS-1:0] CODE_INIT = 15'h3EAC
`ifdef COMBO_LOCK_LOCKOUT_EN
    ,
    parameter int unsigned MAX_FAIL = 3,
    parameter int unsigned LOCK_CYC = 16
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             up,
    input  logic             down,
    input  logic             code_we,
    input  logic [IDX_W-1:0] code_idx,
    input  logic [POS_W-1:0] code_data,
    output logic             open,
    output logic [POS_W-1:0] position,
    output logic [IDX_W:0]   step,
    output logic             locked_out
);

    localparam logic [IDX_W:0] OPEN_ST = (IDX_W+1)'(STEPS);

    logic             cw;
    logic             ccw;
    logic             cw_q;
    logic             ccw_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic [IDX_W:0]   step_q;
    logic [IDX_W:0]   step_d;
    logic [IDX_W:0]   step_nxt;
    logic [POS_W-1:0] code_q [STEPS];
    logic [POS_W-1:0] cur_code;
    logic             is_open;
    logic             dir_ok;
    logic             dir_bad;
    logic             hit;
    logic             code_wr;
    logic             lock_st;
`ifdef COMBO_LOCK_LOCKOUT_EN
    logic             fail;
`endif

    // Decode the buttons; both or neither pressed is no move.
    always_comb begin
        cw  = 1'b0;
        ccw = 1'b0;
        unique case (1'b1)
            up & ~down: cw  = 1'b1;
            down & ~up: ccw = 1'b1;
            default: ;
        endcase
    end

    // Position wraps naturally modulo 2^POS_W.
    always_comb begin
        pos_d = pos_q;
        if (cw) begin
            pos_d = pos_q + POS_W'(1);
        end else if (ccw) begin
            pos_d = pos_q - POS_W'(1);
        end
    end

    // Position and latched move registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos_q <= '0;
            cw_q  <= 1'b0;
            ccw_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            cw_q  <= cw;
            ccw_q <= ccw;
        end
    end

    assign is_open = (step_q == OPEN_ST);
    assign code_wr = code_we && is_open && ({1'b0, code_idx} < OPEN_ST);

    // Combination register file, writable only while open.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                code_q[i] <= CODE_INIT[i*POS_W +: POS_W];
            end
        end else if (code_wr) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                if (code_idx == IDX_W'(i)) begin
                    code_q[i] <= code_data;
                end
            end
        end
    end

    // Select the code entry for the step currently being matched.
    always_comb begin
        cur_code = '0;
        for (int i = 0; i < int'(STEPS); i++) begin
            if (step_q == (IDX_W+1)'(i)) begin
                cur_code = code_q[i];
            end
        end
    end

    // Even steps want clockwise, odd steps counterclockwise.
    assign dir_ok  = step_q[0] ? ccw_q : cw_q;
    assign dir_bad = step_q[0] ? cw_q : ccw_q;
    assign hit     = (pos_q == cur_code);

    // Step FSM next state, built from registered position and move.
    always_comb begin
        step_nxt = step_q;
`ifdef COMBO_LOCK_LOCKOUT_EN
        fail = 1'b0;
`endif
        if (step_q == '0) begin
            if (cw_q && hit) begin
                step_nxt = (IDX_W+1)'(1);
            end
        end else if (step_q == OPEN_ST) begin
            if (cw_q || ccw_q) begin
                step_nxt = '0;
            end
        end else if (dir_bad) begin
            step_nxt = '0;
`ifdef COMBO_LOCK_LOCKOUT_EN
            fail = 1'b1;
`endif
        end else if (dir_ok && hit) begin
            step_nxt = step_q + (IDX_W+1)'(1);
        end
    end

`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMR_W  = $clog2(LOCK_CYC + 1);

    logic [FAIL_W-1:0] fcnt_q;
    logic [FAIL_W-1:0] fcnt_d;
    logic [TMR_W-1:0]  tmr_q;
    logic [TMR_W-1:0]  tmr_d;

    assign lock_st = (tmr_q != '0);

    // Count consecutive failures and run the lockout timer.
    always_comb begin
        fcnt_d = fcnt_q;
        tmr_d  = tmr_q;
        if (lock_st) begin
            tmr_d = tmr_q - TMR_W'(1);
            if (tmr_q == TMR_W'(1)) begin
                fcnt_d = '0;
            end
        end else if (step_nxt == OPEN_ST) begin
            fcnt_d = '0;
        end else if (fail) begin
            fcnt_d = fcnt_q + FAIL_W'(1);
            if (fcnt_q + FAIL_W'(1) == FAIL_W'(MAX_FAIL)) begin
                tmr_d = TMR_W'(LOCK_CYC);
            end
        end
    end

    // Fail counter and lockout timer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= '0;
            tmr_q  <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            tmr_q  <= tmr_d;
        end
    end

    // Lockout pins the step at zero.
    assign step_d = lock_st ? '0 : step_nxt;
`else
    assign lock_st = 1'b0;
    assign step_d  = step_nxt;
`endif

    // Step FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    // Drive outputs from state.
    always_comb begin
        open       = is_open;
        step       = step_q;
        position   = pos_q;
        locked_out = lock_st;
    end

endmodule

// File: tb/tb_combo_lock_gen.sv
// tb_combo_lock_gen: random and directed checks of combo_lock_gen
// against an integer reference model of the lock rules.
module tb_combo_lock_gen;

    localparam int NPOS = 32;
    localparam int NST = 3;
    localparam int MAXF = 3;
    localparam int LCYC = 16;
`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       up;
    logic       down;
    logic       code_we;
    logic [1:0] code_idx;
    logic [4:0] code_data;
    logic       open;
    logic [4:0] position;
    logic [2:0] step;
    logic       locked_out;

    int n_cmp;
    int n_bad;

    int m_pos;
    int m_mv;
    int m_step;
    int m_code[NST];
    int m_fails;
    int m_lock;

    combo_lock_gen dut (
        .clock(clock),
        .reset_n(reset_n),
        .up(up),
        .down(down),
        .code_we(code_we),
        .code_idx(code_idx),
        .code_data(code_data),
        .open(open),
        .position(position),
        .step(step),
        .locked_out(locked_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_mv = 0;
        m_step = 0;
        m_code[0] = 12;
        m_code[1] = 21;
        m_code[2] = 15;
        m_fails = 0;
        m_lock = 0;
    endtask

    // One clock edge of the lock rules, using last cycle's move.
    task automatic model_edge(bit u, bit d, bit we, int idx, int data);
        int mv;
        int nstep;
        int req;
        bit fail;
        mv = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
        nstep = m_step;
        fail = 0;
        if (LOCKOUT && m_lock > 0) begin
            nstep = 0;
        end else if (m_step == NST) begin
            if (m_mv != 0) nstep = 0;
        end else if (m_step == 0) begin
            if (m_mv == 1 && m_pos == m_code[0]) nstep = 1;
        end else begin
            req = (m_step % 2 == 0) ? 1 : -1;
            if (m_mv == -req) begin
                nstep = 0;
                fail = 1;
            end else if (m_mv == req && m_pos == m_code[m_step]) begin
                nstep = m_step + 1;
            end
        end
        if (LOCKOUT) begin
            if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_fails = 0;
            end else if (nstep == NST) begin
                m_fails = 0;
            end else if (fail) begin
                m_fails++;
                if (m_fails == MAXF) m_lock = LCYC;
            end
        end
        if (we && m_step == NST && idx < NST) m_code[idx] = data;
        m_pos = (m_pos + mv + NPOS) % NPOS;
        m_mv = mv;
        m_step = nstep;
    endtask

    task automatic tick(bit u, bit d, bit we = 0, int idx = 0, int data = 0);
        up = u;
        down = d;
        code_we = we;
        code_idx = 2'(idx);
        code_data = 5'(data);
        @(posedge clock);
        model_edge(u, d, we, idx, data);
        #1;
        check("position", 32'(position), 32'(m_pos));
        check("step", 32'(step), 32'(m_step));
        check("open", 32'(open), 32'(m_step == NST));
        check("locked_out", 32'(locked_out), 32'(m_lock > 0));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_position", 32'(position), 0);
        check("rst_step", 32'(step), 0);
        check("rst_open", 32'(open), 0);
        check("rst_locked", 32'(locked_out), 0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Turn in one direction until the model position equals tgt.
    task automatic goto_pos(int tgt, bit cwdir);
        int n;
        n = 0;
        do begin
            tick(cwdir, !cwdir);
            n++;
        end while (m_pos != tgt && n < 40);
    endtask

    task automatic enter_seq(int a, int b, int c);
        goto_pos(a, 1'b1);
        goto_pos(b, 1'b0);
        goto_pos(c, 1'b1);
        tick(0, 0);
    endtask

    initial begin
        int r;
        int cnt;
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b1;
        up = 0;
        down = 0;
        code_we = 0;
        code_idx = '0;
        code_data = '0;
        model_reset();
        do_reset();

        // Default combination: 12 cw, 23 ccw through 0, 26 cw.
        for (int i = 0; i < 12; i++) tick(1, 0);
        for (int i = 0; i < 23; i++) tick(0, 1);
        for (int i = 0; i < 26; i++) tick(1, 0);
        tick(0, 0);
        check("open_after_seq", 32'(open), 1);
        tick(1, 0);
        check("open_on_press", 32'(open), 1);
        tick(0, 0);
        check("open_after_move", 32'(open), 0);

        // Wrong direction at step 1.
        goto_pos(12, 1'b1);
        tick(0, 0);
        check("at_step1", 32'(step), 1);
        tick(1, 0);
        tick(0, 0);
        check("wrong_dir_step", 32'(step), 0);
        check("wrong_dir_open", 32'(open), 0);

        // Wrap below zero and both-pressed neutral input.
        do_reset();
        tick(0, 1);
        check("wrap_pos", 32'(position), 31);
        for (int i = 0; i < 5; i++) tick(1, 1);
        check("neutral_pos", 32'(position), 31);
        check("neutral_step", 32'(step), 0);

        // Reprogramming step 0 to 3 while open.
        do_reset();
        enter_seq(12, 21, 15);
        check("reprog_open", 32'(open), 1);
        tick(0, 0, 1, 0, 3);
        tick(0, 0, 1, 3, 9);
        tick(1, 0);
        tick(0, 0);
        goto_pos(12, 1'b1);
        tick(0, 0);
        check("reprog_old_first", 32'(step), 0);
        enter_seq(3, 21, 15);
        check("reprog_new_open", 32'(open), 1);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0, 1, 0, 7);
        enter_seq(3, 21, 15);
        check("closed_write_drop", 32'(open), 1);

        // Three wrong-direction failures, then an attempt while locked.
        do_reset();
        goto_pos(11, 1'b0);
        for (int f = 0; f < 3; f++) begin
            tick(1, 0);
            tick(1, 0);
            tick(0, 0);
            if (f < 2) begin
                tick(0, 1);
                tick(0, 1);
            end
        end
        check("lock_on", 32'(locked_out), 32'(LOCKOUT));
        cnt = locked_out ? 1 : 0;
        tick(0, 1);
        cnt += locked_out ? 1 : 0;
        tick(0, 1);
        cnt += locked_out ? 1 : 0;
        tick(1, 0);
        cnt += locked_out ? 1 : 0;
        tick(0, 0);
        cnt += locked_out ? 1 : 0;
        check("locked_attempt", 32'(step), LOCKOUT ? 0 : 1);
        for (int i = 0; i < 30; i++) begin
            tick(0, 0);
            cnt += locked_out ? 1 : 0;
        end
        check("lock_cycles", 32'(cnt), LOCKOUT ? LCYC : 0);
        enter_seq(12, 21, 15);
        check("open_after_lock", 32'(open), 1);

        // Asynchronous reset at step 2 restores the default code.
        tick(0, 0, 1, 1, 5);
        tick(1, 0);
        tick(0, 0);
        goto_pos(12, 1'b1);
        goto_pos(5, 1'b0);
        tick(0, 0);
        check("mid_step2", 32'(step), 2);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_position", 32'(position), 0);
        check("async_step", 32'(step), 0);
        check("async_open", 32'(open), 0);
        check("async_locked", 32'(locked_out), 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        enter_seq(12, 21, 15);
        check("code_restored", 32'(open), 1);

        // Random presses with occasional guided entries and writes.
        for (int n = 0; n < 2500; n++) begin
            if (n % 250 == 0) begin
                enter_seq(m_code[0], m_code[1], m_code[2]);
                tick(0, 0, 1, $urandom_range(0, 3), $urandom_range(0, 31));
            end
            r = $urandom_range(0, 9);
            tick(r < 4, r >= 3 && r < 7, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 31));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
